// File: rtl/axis_dispatch4_pkg.sv
// Shared definitions for the axis_dispatch4 1-to-4 AXI-Stream dispatcher.
//   ROUTE_TDEST / ROUTE_RR : values of the ROUTE_MODE parameter
//   N_OUT                  : number of output streams
//   route_state_e          : packet-lock state of the routing FSM
//   rr_next()              : round-robin pointer advance (wraps 3 -> 0)
package axis_dispatch4_pkg;

    localparam int unsigned ROUTE_TDEST = 0;
    localparam int unsigned ROUTE_RR    = 1;
    localparam int unsigned N_OUT       = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,   // no packet open; next flit is a head flit
        ST_LOCKED = 1'b1    // mid-packet; route held in dest_q
    } route_state_e;

    function automatic logic [1:0] rr_next(input logic [1:0] ptr);
        return ptr + 2'd1;
    endfunction

endpackage

// File: rtl/axis_skid_arst.sv
// Two-entry AXI-Stream skid buffer with asynchronous active-low reset.
// Registered outputs and a registered s_ready (not full), giving full
// throughput with one cycle of latency.
//   clk, rst         : clock, async active-low reset (empties the buffer)
//   s_data/valid/ready : upstream side
//   m_data/valid/ready : downstream side, driven straight from registers
module axis_skid_arst #(
    parameter int unsigned DATA_WIDTH = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    logic [DATA_WIDTH-1:0] main_q, skid_q;
    logic                  main_v, skid_v;
    logic                  wr, rd;

    // skid_v only ever sets while main_v is held, so skid_v alone means full
    assign s_ready = !skid_v;
    assign m_valid = main_v;
    assign m_data  = main_q;
    assign wr      = s_valid && !skid_v;
    assign rd      = main_v && m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v || rd) begin
            // output slot frees this cycle: refill from skid first to keep order
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end else begin
                main_v <= wr;
                if (wr) begin
                    main_q <= s_data;
                end
            end
        end else if (wr) begin
            skid_q <= s_data;
            skid_v <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_dispatch4.sv
// 1-to-4 AXI-Stream dispatcher. Each input flit goes to one of four outputs,
// chosen by s_TDEST (ROUTE_MODE=0) or a strict round-robin pointer
// (ROUTE_MODE=1). With TLAST_ARB=1 the head flit's route is held until the
// TLAST flit transfers. PIPE_STAGE=1 inserts a 2-entry skid per output.
//   clk, rst                 : clock, async active-low reset
//   s_TDATA/TVALID/TREADY/TLAST/TDEST : input stream
//   mN_TDATA/TVALID/TREADY/TLAST      : output streams, N = 0..3
module axis_dispatch4
    import axis_dispatch4_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PIPE_STAGE = 1,
    parameter int unsigned TLAST_ARB  = 1,
    parameter int unsigned ROUTE_MODE = ROUTE_TDEST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_TDATA,
    input  logic                  s_TVALID,
    output logic                  s_TREADY,
    input  logic                  s_TLAST,
    input  logic [1:0]            s_TDEST,
    output logic [DATA_WIDTH-1:0] m0_TDATA,
    output logic                  m0_TVALID,
    input  logic                  m0_TREADY,
    output logic                  m0_TLAST,
    output logic [DATA_WIDTH-1:0] m1_TDATA,
    output logic                  m1_TVALID,
    input  logic                  m1_TREADY,
    output logic                  m1_TLAST,
    output logic [DATA_WIDTH-1:0] m2_TDATA,
    output logic                  m2_TVALID,
    input  logic                  m2_TREADY,
    output logic                  m2_TLAST,
    output logic [DATA_WIDTH-1:0] m3_TDATA,
    output logic                  m3_TVALID,
    input  logic                  m3_TREADY,
    output logic                  m3_TLAST
);

    localparam int unsigned FW = DATA_WIDTH + 1;

    route_state_e     state_q, state_d;
    logic [1:0]       dest_q, dest_d;
    logic [1:0]       rr_q, rr_d;
    logic [1:0]       cand, sel;
    logic             undecided;
    logic             s_valid_g, s_xfer;
    logic [FW-1:0]    s_flit;
    logic [N_OUT-1:0] path_valid, path_ready, out_valid, out_ready;
    logic [FW-1:0]    out_flit [N_OUT];

    assign cand      = (ROUTE_MODE == ROUTE_RR) ? rr_q : s_TDEST;
    assign undecided = (TLAST_ARB == 0) || (state_q == ST_IDLE);
    assign sel       = undecided ? cand : dest_q;

    // rst gating keeps input ready and combinational outputs low in reset
    assign s_valid_g = s_TVALID && rst;
    assign s_TREADY  = rst && path_ready[sel];
    assign s_xfer    = s_valid_g && s_TREADY;
    assign s_flit    = {s_TLAST, s_TDATA};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            dest_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        rr_d    = rr_q;
        if (s_xfer) begin
            // a routing decision is made on every transfer while undecided
            if (undecided) begin
                rr_d = rr_next(rr_q);
            end
            if (TLAST_ARB != 0) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!s_TLAST) begin
                            state_d = ST_LOCKED;
                            dest_d  = sel;
                        end
                    end
                    ST_LOCKED: begin
                        if (s_TLAST) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    assign out_ready = {m3_TREADY, m2_TREADY, m1_TREADY, m0_TREADY};

    for (genvar n = 0; n < N_OUT; n++) begin : g_path
        assign path_valid[n] = s_valid_g && (sel == 2'(n));

        if (PIPE_STAGE != 0) begin : g_skid
            axis_skid_arst #(
                .DATA_WIDTH (FW)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .s_data  (s_flit),
                .s_valid (path_valid[n]),
                .s_ready (path_ready[n]),
                .m_data  (out_flit[n]),
                .m_valid (out_valid[n]),
                .m_ready (out_ready[n])
            );
        end else begin : g_comb
            assign out_flit[n]   = s_flit;
            assign out_valid[n]  = path_valid[n];
            assign path_ready[n] = out_ready[n];
        end
    end

    assign m0_TDATA  = out_flit[0][DATA_WIDTH-1:0];
    assign m0_TLAST  = out_flit[0][DATA_WIDTH];
    assign m0_TVALID = out_valid[0];
    assign m1_TDATA  = out_flit[1][DATA_WIDTH-1:0];
    assign m1_TLAST  = out_flit[1][DATA_WIDTH];
    assign m1_TVALID = out_valid[1];
    assign m2_TDATA  = out_flit[2][DATA_WIDTH-1:0];
    assign m2_TLAST  = out_flit[2][DATA_WIDTH];
    assign m2_TVALID = out_valid[2];
    assign m3_TDATA  = out_flit[3][DATA_WIDTH-1:0];
    assign m3_TLAST  = out_flit[3][DATA_WIDTH];
    assign m3_TVALID = out_valid[3];

endmodule

// File: doc/axis_dispatch4.md
Name: axis_dispatch4

Overview:
1-to-4 AXI-Stream dispatcher: the egress counterpart of the 4-to-1 round-robin merge switch.
One input stream is routed to one of four output streams, either by an explicit 2-bit destination or by strict round-robin rotation.
With packet locking enabled, every flit of a packet goes to the same output.
Optional per-output registered skid stage for timing closure.

Parameters:
DATA_WIDTH, 32, width of TDATA on all streams
PIPE_STAGE, 1, 1 = registered skid buffer on each output; 0 = purely combinational datapath
TLAST_ARB, 1, 1 = route decision held from head flit until TLAST flit transfers; 0 = every flit routed independently
ROUTE_MODE, 0, 0 = route by s_TDEST; 1 = strict round-robin 0,1,2,3,0,... (s_TDEST ignored)

Ports:
clk  in  1  sole clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
s_TDATA  in  DATA_WIDTH  input data
s_TVALID  in  1  input valid
s_TREADY  out  1  input ready
s_TLAST  in  1  end of packet (used only when TLAST_ARB=1; always forwarded)
s_TDEST  in  2  destination index (ROUTE_MODE=0 only)
mN_TDATA  out  DATA_WIDTH  output data, N=0..3
mN_TVALID  out  1  output valid, N=0..3
mN_TREADY  in  1  output ready, N=0..3
mN_TLAST  out  1  output last, N=0..3

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst). Assertion clears all state immediately; deassertion is synchronous to clk.
- State:
  - undecided (reset 1)
  - dest_r[1:0] (reset 0)
  - rr_ptr[1:0] (reset 0)
  - skid contents (reset empty)
- Reset outputs: all mN_TVALID=0; s_TREADY=0 while rst low. mN_TDATA/mN_TLAST are don't-care while valid is low.
- Candidate destination: s_TDEST when ROUTE_MODE=0, else rr_ptr.
- Effective destination: sel = undecided ? candidate : dest_r.
- TLAST_ARB=1, two states:
  - IDLE (undecided=1): on a flit transfer with s_TLAST=0, latch dest_r<=sel and go to LOCKED. A single-flit packet (TLAST=1 on head) stays in IDLE.
  - LOCKED: s_TDEST is ignored. On a transfer with s_TLAST=1, return to IDLE.
- TLAST_ARB=0: undecided is held at 1 permanently; every flit uses the candidate destination.
- Round-robin: rr_ptr increments (mod 4, wraps 3->0) on each routing decision:
  - TLAST_ARB=1: on every transfer made while undecided=1.
  - TLAST_ARB=0: on every transfer.
- No skipping of busy outputs.
- Datapath:
  - Only output sel sees valid = s_TVALID; the other three see valid 0.
  - s_TREADY = ready of the selected output path.
  - No head-of-line bypass: a stalled destination stalls the input.
- PIPE_STAGE=0:
  - mN_* are combinational from s_*; latency 0.
  - s_TREADY = m[sel]_TREADY, combinational.
- PIPE_STAGE=1:
  - Each output has a 2-entry skid buffer; latency 1 cycle.
  - Full throughput (1 flit/cycle) per output when downstream is ready.
  - s_TREADY = registered ready of the selected skid, i.e. not full.
  - mN_TVALID/TDATA/TLAST are driven directly from registers.
- Handshake rules:
  - Transfer = TVALID & TREADY.
  - Once mN_TVALID is asserted, it and mN_TDATA/mN_TLAST are held stable until transfer.
  - mN_TVALID never depends combinationally on mN_TREADY.
- Simultaneous events: a skid may enqueue and dequeue in the same cycle; occupancy is unchanged.
- Reset mid-packet: packet lock is dropped and buffered flits are discarded. The next flit after reset is treated as a head flit.
- Flits are never dropped, duplicated or reordered per output.

Decomposition:
- macros.vh gains ROUTE_TDEST=0 and ROUTE_RR=1. Existing AXIS port macros are used for all stream ports.
- Sub-module: axis_skid_arst.
  - Parameter DATA_WIDTH; async active-low reset.
  - 2-entry skid buffer, instantiated 4x with width DATA_WIDTH+1 to carry TLAST.
  - Generate-selected when PIPE_STAGE=1.
- Routing FSM, rr_ptr and demux live in the top module.

Test Plan:
1. ROUTE_MODE=0, TLAST_ARB=1, all ready: 3-flit packet TDEST=2 (data 0xA0,0xA1,0xA2; TDEST toggles to 1 on flit 2) -> all three flits appear only on m2; TLAST on 0xA2; m0/m1/m3 TVALID stay 0.
2. Backpressure, PIPE_STAGE=1: m1_TREADY=0, stream 4 flits TDEST=1 -> 2 flits accepted, then s_TREADY=0. Release m1_TREADY -> in-order delivery 1/cycle, no loss.
3. ROUTE_MODE=1, TLAST_ARB=1: five 2-flit packets -> packets go to m0,m1,m2,m3,m0 (wrap-around); rr_ptr advances once per packet.
4. ROUTE_MODE=1, TLAST_ARB=0: 6 single flits with TLAST=0 -> m0,m1,m2,m3,m0,m1.
5. Async reset mid-packet: assert rst low after flit 1 of a TDEST=3 packet, off-edge -> all mN_TVALID drop to 0 immediately. After release, a new packet with TDEST=0 routes to m0.
6. Single-flit packets, back-to-back, TDEST=0,3,0 with TLAST=1 -> each routed per its own TDEST at full rate; FSM never leaves IDLE.
